// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one-cycle-latency reads to
// IMEM/BIOS and buffers returned words in a small in-order queue whose head is
// presented combinationally to the decoder. Redirects flush the queue and drop
// the response still in flight.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     fetch_pc;
    logic            inflight;
    logic [31:0]     inflight_pc;
    logic [31:0]     inst_q [QDEPTH];
    logic [31:0]     pc_q   [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            pop;
    logic            push;
    logic            issue;
    logic            take_redirect;
    logic            unused_rpc_lsbs;

    // Low address bits of the redirect target are discarded by design.
    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // Head of queue drives the decoder directly; empty queue shows a NOP.
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? inst_q[rd_ptr] : NOP;
    assign pc         = inst_valid ? pc_q[rd_ptr]   : 32'h0;
    assign imem_en    = issue;
    assign imem_addr  = fetch_pc;

    // Handshake decode, issue credit and next-state selection.
    always_comb begin
        state_nxt     = state;
        take_redirect = redirect && (state != BOOT);
        pop           = inst_valid && !stall && !redirect;
        push          = inflight && (state == RUN) && !take_redirect;
        // Words already owed to the queue after this cycle's pop; a new read
        // is only allowed if its word is guaranteed a free slot.
        credit        = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        issue         = (state != BOOT) && !redirect && (credit < {1'b0, FULL});
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = take_redirect ? FLUSH : RUN;
            FLUSH:   state_nxt = take_redirect ? FLUSH : RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Control state: FSM, fetch PC, in-flight flag and queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (take_redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (push)  wr_ptr   <= wr_ptr + PW'(1);
                if (pop)   rd_ptr   <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Remember which address the outstanding read belongs to.
    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= fetch_pc;
    end

    // Queue storage: returned word and its PC written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= inflight_pc;
        end
    end

    // Issue credit must keep the queue from ever being written while full.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count == FULL)));

endmodule
